hypercord_iter_ctrl: RTL and testbench

//  Iterative hyperbolic-CORDIC sequencer (rotation mode): accepts one (X,Y,Z) triple, applies stage1 range
//  pre-rotation on accept, then drives one shared micro-rotation unit for every iteration index, repeats included.

---
 rtl/hypercord_iter_ctrl_pkg.sv | 74 +++++++
 rtl/hypercord_iter_ctrl_microrot.sv | 93 +++++++++
 rtl/hypercord_iter_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hypercord_iter_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hypercord_iter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hypercord_iter_ctrl_pkg
//
// Purpose:
//   Shared constants, types and helpers for the iterative hyperbolic CORDIC
//   sequencer (hypercord_iter_ctrl) and its datapath sub-modules.
//
// Contents:
//   HC_IDXW       width of the shift index i
//   HC_LUT_FRA    fractional bits of the master arctanh table (Q2.30)
//   hc_state_t    sequencer state encoding (IDLE / ITER / DONE)
//   ATANH_LUT     atanh(2^-i) for i = 0..63, Q2.30, entry 0 unused
//   HC_ZLIM_Q30   largest |Z| the iteration set converges for, with margin
//   is_rep_idx()  true for shift indices that must be executed twice
//   hc_scale()    round a Q2.30 constant down to an arbitrary fraction width
//   hc_lut_q()    atanh(2^-i) rounded to a given fraction width
// -----------------------------------------------------------------------------
package hypercord_iter_ctrl_pkg;

   localparam int HC_IDXW    = 6;
   localparam int HC_LUT_FRA = 30;

   typedef enum logic [1:0] {
      HC_IDLE = 2'd0,
      HC_ITER = 2'd1,
      HC_DONE = 2'd2
   } hc_state_t;

   // atanh(2^-i) * 2^30. Entry 0 (atanh(1)) is infinite and never addressed.
   // From i = 11 on, atanh(2^-i) equals 2^-i to well below 1 LSB of Q2.30.
   localparam logic [31:0] ATANH_LUT [0:63] = '{
      32'd0,         32'd589812981, 32'd274247419, 32'd134923406,
      32'd67196451,  32'd33565361,  32'd16778582,  32'd8388779,
      32'd4194325,   32'd2097155,   32'd1048576,   32'd524288,
      32'd262144,    32'd131072,    32'd65536,     32'd32768,
      32'd16384,     32'd8192,      32'd4096,      32'd2048,
      32'd1024,      32'd512,       32'd256,       32'd128,
      32'd64,        32'd32,        32'd16,        32'd8,
      32'd4,         32'd2,         32'd1,         32'd0,
      32'd0,         32'd0,         32'd0,         32'd0,
      32'd0,         32'd0,         32'd0,         32'd0,
      32'd0,         32'd0,         32'd0,         32'd0,
      32'd0,         32'd0,         32'd0,         32'd0,
      32'd0,         32'd0,         32'd0,         32'd0,
      32'd0,         32'd0,         32'd0,         32'd0,
      32'd0,         32'd0,         32'd0,         32'd0,
      32'd0,         32'd0,         32'd0,         32'd0
   };

   // 1.1172 in Q2.30: just inside the ~1.1182 convergence bound of the
   // i = 1..16 sequence with repeats, so a clamped operand still converges.
   localparam logic [31:0] HC_ZLIM_Q30 = 32'd1199584366;

   // Indices k' = 3k + 1 (4, 13, 40) are run twice for hyperbolic convergence.
   function automatic logic is_rep_idx(input logic [HC_IDXW-1:0] i);
      return (i == 6'd4) || (i == 6'd13) || (i == 6'd40);
   endfunction

   // Round-half-up conversion from Q2.30 to 'fra' fractional bits.
   function automatic logic [31:0] hc_scale(input logic [31:0] v, input int fra);
      logic [32:0] acc;
      acc = {1'b0, v};
      if (fra < HC_LUT_FRA) begin
         acc = acc + (33'd1 << (HC_LUT_FRA - fra - 1));
         acc = acc >> (HC_LUT_FRA - fra);
      end
      return acc[31:0];
   endfunction

   function automatic logic [31:0] hc_lut_q(input logic [HC_IDXW-1:0] i, input int fra);
      return hc_scale(ATANH_LUT[i], fra);
   endfunction

endpackage

// File: rtl/hypercord_iter_ctrl_microrot.sv
// -----------------------------------------------------------------------------
// hypercord_microrot / hypercord_stage1
//
// Purpose:
//   Combinational datapath pieces of the hyperbolic CORDIC sequencer.
//
// hypercord_microrot: one hyperbolic micro-rotation
//   x_i, y_i, z_i  [DWIDTH]  current vector and residual angle
//   idx_i          [6]       shift index i
//   neg_i          [1]       1 selects d = -1, 0 selects d = +1
//   x_o, y_o, z_o  [DWIDTH]  X + d*(Y>>>i), Y + d*(X>>>i), Z - d*atanh(2^-i)
//
// hypercord_stage1: operand pre-conditioning on accept
//   x_i, y_i, z_i  [DWIDTH]  raw operands
//   x_o, y_o, z_o  [DWIDTH]  X, Y unchanged; Z folded into the convergence range
//
// All arithmetic is two's complement and wraps modulo 2^DWIDTH.
// -----------------------------------------------------------------------------
module hypercord_microrot
   import hypercord_iter_ctrl_pkg::*;
#(
   parameter int FRA_WIDTH = 14,
   parameter int DWIDTH    = 18
) (
   input  logic [DWIDTH-1:0]  x_i,
   input  logic [DWIDTH-1:0]  y_i,
   input  logic [DWIDTH-1:0]  z_i,
   input  logic [HC_IDXW-1:0] idx_i,
   input  logic               neg_i,
   output logic [DWIDTH-1:0]  x_o,
   output logic [DWIDTH-1:0]  y_o,
   output logic [DWIDTH-1:0]  z_o
);

   logic [DWIDTH-1:0] x_sh;
   logic [DWIDTH-1:0] y_sh;
   logic [DWIDTH-1:0] ang;

   // Arithmetic shift: floor division by 2^i, truncation bias is accepted.
   assign x_sh = DWIDTH'($signed(x_i) >>> idx_i);
   assign y_sh = DWIDTH'($signed(y_i) >>> idx_i);
   assign ang  = DWIDTH'(hc_lut_q(idx_i, FRA_WIDTH));

   always_comb begin
      if (neg_i) begin
         x_o = x_i - y_sh;
         y_o = y_i - x_sh;
         z_o = z_i + ang;
      end else begin
         x_o = x_i + y_sh;
         y_o = y_i + x_sh;
         z_o = z_i - ang;
      end
   end

endmodule

module hypercord_stage1
   import hypercord_iter_ctrl_pkg::*;
#(
   parameter int FRA_WIDTH = 14,
   parameter int DWIDTH    = 18
) (
   input  logic [DWIDTH-1:0] x_i,
   input  logic [DWIDTH-1:0] y_i,
   input  logic [DWIDTH-1:0] z_i,
   output logic [DWIDTH-1:0] x_o,
   output logic [DWIDTH-1:0] y_o,
   output logic [DWIDTH-1:0] z_o
);

   logic [DWIDTH-1:0] zlim_pos;
   logic [DWIDTH-1:0] zlim_neg;

   assign zlim_pos = DWIDTH'(hc_scale(HC_ZLIM_Q30, FRA_WIDTH));
   assign zlim_neg = '0 - zlim_pos;

   assign x_o = x_i;
   assign y_o = y_i;

   // Out-of-range angles (including the most-negative code) are pulled to the
   // nearest convergent angle so the residual still drives toward zero.
   always_comb begin
      if ($signed(z_i) > $signed(zlim_pos)) begin
         z_o = zlim_pos;
      end else if ($signed(z_i) < $signed(zlim_neg)) begin
         z_o = zlim_neg;
      end else begin
         z_o = z_i;
      end
   end

endmodule

// File: rtl/hypercord_iter_ctrl.sv
// -----------------------------------------------------------------------------
// hypercord_iter_ctrl
//
// Purpose:
//   Iterative hyperbolic CORDIC sequencer in rotation mode. Accepts one
//   (X, Y, Z) triple, conditions it through hypercord_stage1, then runs one
//   shared hypercord_microrot per cycle for i = 1..NITER with indices 4, 13, 40
//   executed twice. Result: X ~ K*cosh-scaled, Y ~ K*sinh-scaled, Z ~ 0.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset, discards any operation
//   in_valid/ready   operand handshake; in_ready high only in IDLE
//   Xin, Yin, Zin    operands [DWIDTH], FRA_WIDTH fractional bits
//   out_valid/ready  result handshake; result held until out_ready
//   Xout, Yout, Zout result [DWIDTH]
//   busy             high while iterating or holding a result
//   iter_idx         current shift index i [6], 0 outside ITER
//
// Configuration:
//   HYPERCORD_EARLY_TERM_EN  when defined, an ITER cycle that starts with
//                            Z == 0 performs no rotation and finishes.
// -----------------------------------------------------------------------------
module hypercord_iter_ctrl
   import hypercord_iter_ctrl_pkg::*;
#(
   parameter int FRA_WIDTH = 14,
   parameter int DWIDTH    = 18,
   parameter int NITER     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DWIDTH-1:0]  Xin,
   input  logic [DWIDTH-1:0]  Yin,
   input  logic [DWIDTH-1:0]  Zin,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DWIDTH-1:0]  Xout,
   output logic [DWIDTH-1:0]  Yout,
   output logic [DWIDTH-1:0]  Zout,
   output logic               busy,
   output logic [HC_IDXW-1:0] iter_idx
);

   localparam logic [1:0]         S_IDLE    = HC_IDLE;
   localparam logic [1:0]         S_ITER    = HC_ITER;
   localparam logic [1:0]         S_DONE    = HC_DONE;
   localparam logic [HC_IDXW-1:0] NITER_IDX = HC_IDXW'(NITER);

   logic [1:0]         state_q, state_d;
   logic [DWIDTH-1:0]  x_q, x_d;
   logic [DWIDTH-1:0]  y_q, y_d;
   logic [DWIDTH-1:0]  z_q, z_d;
   logic [HC_IDXW-1:0] idx_q, idx_d;
   logic               rep_q, rep_d;

   logic [DWIDTH-1:0]  s1_x, s1_y, s1_z;
   logic [DWIDTH-1:0]  mr_x, mr_y, mr_z;
   logic               early_stop;

   hypercord_stage1 #(
      .FRA_WIDTH (FRA_WIDTH),
      .DWIDTH    (DWIDTH)
   ) u_stage1 (
      .x_i (Xin),
      .y_i (Yin),
      .z_i (Zin),
      .x_o (s1_x),
      .y_o (s1_y),
      .z_o (s1_z)
   );

   // d = -1 when Z is negative; zero counts as positive.
   hypercord_microrot #(
      .FRA_WIDTH (FRA_WIDTH),
      .DWIDTH    (DWIDTH)
   ) u_microrot (
      .x_i   (x_q),
      .y_i   (y_q),
      .z_i   (z_q),
      .idx_i (idx_q),
      .neg_i (z_q[DWIDTH-1]),
      .x_o   (mr_x),
      .y_o   (mr_y),
      .z_o   (mr_z)
   );

`ifdef HYPERCORD_EARLY_TERM_EN
   assign early_stop = (z_q == '0);
`else
   assign early_stop = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      idx_d   = idx_q;
      rep_d   = rep_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d     = s1_x;
               y_d     = s1_y;
               z_d     = s1_z;
               idx_d   = HC_IDXW'(1);
               rep_d   = 1'b0;
               state_d = S_ITER;
            end
         end

         S_ITER: begin
            if (early_stop) begin
               idx_d   = '0;
               rep_d   = 1'b0;
               state_d = S_DONE;
            end else begin
               x_d = mr_x;
               y_d = mr_y;
               z_d = mr_z;
               // A repeat index is checked before the end test so that a
               // repeat at i == NITER still runs its second pass.
               if (is_rep_idx(idx_q) && !rep_q) begin
                  rep_d = 1'b1;
               end else if (idx_q == NITER_IDX) begin
                  idx_d   = '0;
                  rep_d   = 1'b0;
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + HC_IDXW'(1);
                  rep_d = 1'b0;
               end
            end
         end

         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         idx_q   <= '0;
         rep_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_ITER) || (state_q == S_DONE);
   assign iter_idx  = idx_q;
   assign Xout      = x_q;
   assign Yout      = y_q;
   assign Zout      = z_q;

endmodule

// File: tb/tb_hypercord_iter_ctrl.sv
module tb_hypercord_iter_ctrl;

   localparam int TOL = 4;

`ifdef HYPERCORD_EARLY_TERM_EN
   localparam int LAT_ZERO = 1;
   localparam int X_ZERO   = 19784;
`else
   localparam int LAT_ZERO = 18;
   localparam int X_ZERO   = 16384;
`endif
   localparam int LAT_FULL = 18;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] Xin, Yin, Zin;
   logic        out_valid;
   logic        out_ready;
   logic [17:0] Xout, Yout, Zout;
   logic        busy;
   logic [5:0]  iter_idx;

   int checks;
   int failures;
   logic [5:0] trace[$];

   hypercord_iter_ctrl #(
      .FRA_WIDTH (14),
      .DWIDTH    (18),
      .NITER     (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Xin       (Xin),
      .Yin       (Yin),
      .Zin       (Zin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Xout      (Xout),
      .Yout      (Yout),
      .Zout      (Zout),
      .busy      (busy),
      .iter_idx  (iter_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one operand triple for one cycle; called at a negedge in IDLE.
   task automatic accept(input logic [17:0] x, input logic [17:0] y, input logic [17:0] z);
      Xin = x; Yin = y; Zin = z; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Counts cycles from the accept edge until out_valid, recording iter_idx.
   task automatic wait_done(output int lat);
      lat = 0;
      trace.delete();
      while (out_valid !== 1'b1 && lat < 100) begin
         trace.push_back(iter_idx);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      int seen;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (iter_idx !== 6'd0) begin failures++; $display("FAIL rst_iter_idx got=%0d exp=0", iter_idx); end
      checks++; if ({Xout, Yout, Zout} !== 54'd0) begin failures++; $display("FAIL rst_data got=%h/%h/%h exp=0", Xout, Yout, Zout); end

      accept(18'd19784, 18'd0, 18'd8192);
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
      checks++; if (iter_idx !== 6'd4) begin failures++; $display("FAIL mid_iter_idx got=%0d exp=4", iter_idx); end

      rst = 1'b1; in_valid = 1'b1; Xin = 18'd100; Yin = 18'd200; Zin = 18'd300;
      repeat (3) @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
      checks++; if (iter_idx !== 6'd0) begin failures++; $display("FAIL rst_mid_iter_idx got=%0d exp=0", iter_idx); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_nothing_accepted busy got=%b exp=0", busy); end
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL rst_late_result got=%0d exp=0", seen); end
   endtask

   task automatic test_zero();
      int lat;
      accept(18'd19784, 18'd0, 18'd0);
      wait_done(lat);
      checks++; if (lat !== LAT_ZERO) begin failures++; $display("FAIL zero_latency got=%0d exp=%0d", lat, LAT_ZERO); end
      checks++; if (int'($signed(Xout)) - X_ZERO > TOL || int'($signed(Xout)) - X_ZERO < -TOL) begin failures++; $display("FAIL zero_x got=%0d exp=%0d", $signed(Xout), X_ZERO); end
      checks++; if (int'($signed(Yout)) > TOL || int'($signed(Yout)) < -TOL) begin failures++; $display("FAIL zero_y got=%0d exp=0", $signed(Yout)); end
      checks++; if (int'($signed(Zout)) > TOL || int'($signed(Zout)) < -TOL) begin failures++; $display("FAIL zero_z got=%0d exp=0", $signed(Zout)); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL zero_release got=%b%b exp=01", out_valid, in_ready); end
   endtask

   task automatic test_pos_half();
      int lat;
      accept(18'd19784, 18'd0, 18'd8192);
      wait_done(lat);
`ifndef HYPERCORD_EARLY_TERM_EN
      checks++; if (lat !== LAT_FULL) begin failures++; $display("FAIL pos_latency got=%0d exp=%0d", lat, LAT_FULL); end
`endif
      checks++; if (int'($signed(Xout)) - 18475 > TOL || int'($signed(Xout)) - 18475 < -TOL) begin failures++; $display("FAIL pos_x got=%0d exp=18475", $signed(Xout)); end
      checks++; if (int'($signed(Yout)) - 8538 > TOL || int'($signed(Yout)) - 8538 < -TOL) begin failures++; $display("FAIL pos_y got=%0d exp=8538", $signed(Yout)); end
      checks++; if (int'($signed(Zout)) > TOL || int'($signed(Zout)) < -TOL) begin failures++; $display("FAIL pos_z got=%0d exp=0", $signed(Zout)); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_neg_half();
      int lat;
      int exp_tr[18] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15, 16};
      accept(18'd19784, 18'd0, 18'h3E000);
      wait_done(lat);
`ifndef HYPERCORD_EARLY_TERM_EN
      checks++; if (trace.size() !== 18) begin failures++; $display("FAIL neg_trace_len got=%0d exp=18", trace.size()); end
      for (int i = 0; i < 18; i++) begin
         if (i < trace.size()) begin
            checks++; if (int'(trace[i]) !== exp_tr[i]) begin failures++; $display("FAIL neg_trace[%0d] got=%0d exp=%0d", i, trace[i], exp_tr[i]); end
         end
      end
`endif
      checks++; if (int'($signed(Xout)) - 18475 > TOL || int'($signed(Xout)) - 18475 < -TOL) begin failures++; $display("FAIL neg_x got=%0d exp=18475", $signed(Xout)); end
      checks++; if (int'($signed(Yout)) + 8538 > TOL || int'($signed(Yout)) + 8538 < -TOL) begin failures++; $display("FAIL neg_y got=%0d exp=-8538", $signed(Yout)); end
      checks++; if (int'($signed(Zout)) > TOL || int'($signed(Zout)) < -TOL) begin failures++; $display("FAIL neg_z got=%0d exp=0", $signed(Zout)); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_hold();
      int lat;
      logic [53:0] first;
      accept(18'd19784, 18'd0, 18'd8192);
      wait_done(lat);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_reached got=%b exp=1", out_valid); end
      first = {Xout, Yout, Zout};
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0];
         Xin = 18'd1000; Yin = 18'd2000; Zin = 18'd3000;
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL hold_flags[%0d] got=%b%b%b exp=101", c, out_valid, in_ready, busy); end
         checks++; if ({Xout, Yout, Zout} !== first) begin failures++; $display("FAIL hold_stable[%0d] got=%h exp=%h", c, {Xout, Yout, Zout}, first); end
         checks++; if (int'($signed(Yout)) - 8538 > TOL || int'($signed(Yout)) - 8538 < -TOL) begin failures++; $display("FAIL hold_y[%0d] got=%0d exp=8538", c, $signed(Yout)); end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL hold_release got=%b%b exp=10", in_ready, busy); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_no_accept got=%b exp=0", busy); end
   endtask

   task automatic test_most_neg();
      int lat;
      accept(18'd19784, 18'd0, 18'h20000);
      wait_done(lat);
`ifndef HYPERCORD_EARLY_TERM_EN
      checks++; if (lat !== LAT_FULL) begin failures++; $display("FAIL mneg_latency got=%0d exp=%0d", lat, LAT_FULL); end
`endif
      checks++; if ($signed(Yout) >= 0) begin failures++; $display("FAIL mneg_y_sign got=%0d exp=<0", $signed(Yout)); end
      checks++; if ($signed(Xout) <= 18'sd16384) begin failures++; $display("FAIL mneg_x got=%0d exp=>16384", $signed(Xout)); end
      checks++; if (int'($signed(Zout)) > TOL || int'($signed(Zout)) < -TOL) begin failures++; $display("FAIL mneg_z got=%0d exp=0", $signed(Zout)); end
      rst = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_same got=%b%b exp=01", out_valid, in_ready); end
   endtask

   task automatic test_back_to_back();
      int lat;
      accept(18'd19784, 18'd0, 18'd8192);
      wait_done(lat);
      out_ready = 1'b1; in_valid = 1'b1;
      Xin = 18'd19784; Yin = 18'd0; Zin = 18'd0;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_no_accept_in_done got=%b%b exp=01", out_valid, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || iter_idx !== 6'd1) begin failures++; $display("FAIL b2b_accept got=%b/%0d exp=1/1", busy, iter_idx); end
      wait_done(lat);
      checks++; if (lat !== LAT_ZERO) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT_ZERO); end
      checks++; if (int'($signed(Xout)) - X_ZERO > TOL || int'($signed(Xout)) - X_ZERO < -TOL) begin failures++; $display("FAIL b2b_x got=%0d exp=%0d", $signed(Xout), X_ZERO); end
      checks++; if (int'($signed(Yout)) > TOL || int'($signed(Yout)) < -TOL) begin failures++; $display("FAIL b2b_y got=%0d exp=0", $signed(Yout)); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      Xin = '0; Yin = '0; Zin = '0;
      test_reset();
      test_zero();
      test_pos_half();
      test_neg_half();
      test_hold();
      test_most_neg();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
